tpu_cmd_sequencer: RTL and testbench

Parametrised command front-end for the TPU core. It replaces the free-running host control pins (UB read start/pointer/address/sizes, VPU pathway, systolic switch) with a queued command interface and a sequencing FSM. Each command drives the unified buffer read port and the systolic/VPU control lines. The block tracks completion by counting VPU writeback beats on an N-lane array, and reports busy, completion and timeout status to the host.

---
 rtl/tpu_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_tpu_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tpu_cmd_sequencer : queued host command front-end sequencing UB reads and
//                     systolic/VPU control, with completion/timeout status.
// Revision 1.0
// ============================================================================
module tpu_cmd_sequencer #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int CMD_FIFO_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid_in,
    output logic                              cmd_ready_out,
    input  logic [1:0]                        cmd_op_in,
    input  logic                              cmd_transpose_in,
    input  logic [8:0]                        cmd_ptr_select_in,
    input  logic [15:0]                       cmd_addr_in,
    input  logic [15:0]                       cmd_row_size_in,
    input  logic [15:0]                       cmd_col_size_in,
    input  logic [3:0]                        cmd_vpu_pathway_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]   vpu_valid_in,
    input  logic                              err_clear_in,
    output logic                              ub_rd_start_out,
    output logic                              ub_rd_transpose_out,
    output logic [8:0]                        ub_ptr_select_out,
    output logic [15:0]                       ub_rd_addr_out,
    output logic [15:0]                       ub_rd_row_size_out,
    output logic [15:0]                       ub_rd_col_size_out,
    output logic [3:0]                        vpu_data_pathway_out,
    output logic                              sys_switch_out,
    output logic                              sync_pulse_out,
    output logic                              busy_out,
    output logic [$clog2(CMD_FIFO_DEPTH):0]   fifo_count_out,
    output logic [15:0]                       cmd_done_count_out,
    output logic                              err_timeout_out
);
    localparam int PW = $clog2(CMD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_LOAD = 2'd2;
    localparam logic [1:0] ST_WAIT_WB   = 2'd3;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_COMPUTE = 2'd1;
    localparam logic [1:0] OP_SWITCH  = 2'd2;
    localparam logic [1:0] OP_SYNC    = 2'd3;

    logic [63:0]   mem_q [CMD_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [63:0]   head;
    logic [1:0]    head_op;
    logic [15:0]   head_row;
    logic          head_lc;

    logic [1:0]  state_q, state_d, op_q, op_d;
    logic        tr_q, tr_d;
    logic [8:0]  ptr_q, ptr_d;
    logic [15:0] addr_q, addr_d, row_q, row_d, col_q, col_d;
    logic [3:0]  pw_q, pw_d;
    logic        start_q, start_d, switch_q, switch_d, sync_q, sync_d;
    logic [16:0] timer_q, timer_d;
    logic [15:0] beat_q, beat_d, beat_next;
    logic [TW-1:0] idle_q, idle_d;
    logic [15:0] done_q, done_d;
    logic        err_q, err_d, busy_q, busy_d, retire, last_lane;
    logic        unused_lanes;

    assign cmd_ready_out = (count_q != CW'(CMD_FIFO_DEPTH));
    assign push          = cmd_valid_in && cmd_ready_out;
    assign pop           = (state_q == ST_IDLE) && (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign head_op       = head[63:62];
    assign head_row      = head[35:20];
    assign head_lc       = (head_op == OP_LOAD) || (head_op == OP_COMPUTE);
    assign last_lane     = vpu_valid_in[SYSTOLIC_ARRAY_WIDTH-1];
    assign beat_next     = beat_q + {15'd0, last_lane};
    assign unused_lanes  = ^vpu_valid_in;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tr_d     = tr_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        row_d    = row_q;
        col_d    = col_q;
        pw_d     = pw_q;
        start_d  = 1'b0;
        switch_d = 1'b0;
        sync_d   = 1'b0;
        timer_d  = timer_q;
        beat_d   = beat_q;
        idle_d   = idle_q;
        done_d   = done_q;
        err_d    = err_q & ~err_clear_in;
        retire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_ISSUE;
                    op_d    = head_op;
                    beat_d  = '0;
                    // SWITCH/SYNC leave the held UB/VPU fields untouched
                    if (head_lc) begin
                        tr_d   = head[61];
                        ptr_d  = head[60:52];
                        addr_d = head[51:36];
                        row_d  = head_row;
                        col_d  = head[19:4];
                        pw_d   = head[3:0];
                    end
                    start_d  = head_lc && (head_row != 16'd0);
                    switch_d = ((head_op == OP_COMPUTE) && (head_row != 16'd0))
                               || (head_op == OP_SWITCH);
                    sync_d   = (head_op == OP_SYNC);
                end
            end
            ST_ISSUE: begin
                idle_d = '0;
                beat_d = beat_next;
                if ((op_q == OP_LOAD) && (row_q != 16'd0)) begin
                    timer_d = {1'b0, row_q} + 17'(SYSTOLIC_ARRAY_WIDTH - 1);
                    state_d = ST_WAIT_LOAD;
                end else if ((op_q == OP_COMPUTE) && (row_q != 16'd0)
                             && (beat_next != row_q)) begin
                    state_d = ST_WAIT_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_WAIT_LOAD: begin
                timer_d = timer_q - 17'd1;
                if (timer_q == 17'd1) begin
                    retire = 1'b1;
                end
            end
            ST_WAIT_WB: begin
                if (last_lane) begin
                    beat_d = beat_next;
                    idle_d = '0;
                    if (beat_next == row_q) begin
                        retire = 1'b1;
                    end
                end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // abort without retiring; the sticky flag beats a same-cycle clear
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (retire) begin
            state_d = ST_IDLE;
            done_d  = done_q + 16'd1;
        end
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op_in, cmd_transpose_in, cmd_ptr_select_in, cmd_addr_in,
                                cmd_row_size_in, cmd_col_size_in, cmd_vpu_pathway_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            tr_q     <= 1'b0;
            ptr_q    <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pw_q     <= '0;
            start_q  <= 1'b0;
            switch_q <= 1'b0;
            sync_q   <= 1'b0;
            timer_q  <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q  <= count_d;
            state_q  <= state_d;
            op_q     <= op_d;
            tr_q     <= tr_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pw_q     <= pw_d;
            start_q  <= start_d;
            switch_q <= switch_d;
            sync_q   <= sync_d;
            timer_q  <= timer_d;
            beat_q   <= beat_d;
            idle_q   <= idle_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign ub_rd_start_out      = start_q;
    assign ub_rd_transpose_out  = tr_q;
    assign ub_ptr_select_out    = ptr_q;
    assign ub_rd_addr_out       = addr_q;
    assign ub_rd_row_size_out   = row_q;
    assign ub_rd_col_size_out   = col_q;
    assign vpu_data_pathway_out = pw_q;
    assign sys_switch_out       = switch_q;
    assign sync_pulse_out       = sync_q;
    assign busy_out             = busy_q;
    assign fifo_count_out       = count_q;
    assign cmd_done_count_out   = done_q;
    assign err_timeout_out      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tpu_cmd_sequencer : vector table plus corner sequences, with a pulse
//                        scoreboard checking every issue cycle.
// Revision 1.0
// ============================================================================
module tb_tpu_cmd_sequencer;
    localparam int N    = 2;
    localparam int N4   = 4;
    localparam int DEPTH = 4;
    localparam int TMO  = 16;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_COMPUTE = 2'd1, OP_SWITCH = 2'd2, OP_SYNC = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_valid4, tr, err_clear, err_clear4;
    logic [1:0]  op;
    logic [8:0]  ptr;
    logic [15:0] addr, row, col;
    logic [3:0]  pw;
    logic [N-1:0]  vpu;
    logic [N4-1:0] vpu4;

    logic        ready, start, o_tr, sw, sync, busy, err;
    logic [8:0]  o_ptr;
    logic [15:0] o_addr, o_row, o_col, done;
    logic [3:0]  o_pw;
    logic [2:0]  count;

    logic        ready4, start4, o_tr4, sw4, sync4, busy4, err4;
    logic [8:0]  o_ptr4;
    logic [15:0] o_addr4, o_row4, o_col4, done4;
    logic [3:0]  o_pw4;
    logic [2:0]  count4;

    tpu_cmd_sequencer #(.SYSTOLIC_ARRAY_WIDTH(N), .CMD_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid_in(cmd_valid), .cmd_ready_out(ready),
        .cmd_op_in(op), .cmd_transpose_in(tr), .cmd_ptr_select_in(ptr), .cmd_addr_in(addr),
        .cmd_row_size_in(row), .cmd_col_size_in(col), .cmd_vpu_pathway_in(pw),
        .vpu_valid_in(vpu), .err_clear_in(err_clear), .ub_rd_start_out(start),
        .ub_rd_transpose_out(o_tr), .ub_ptr_select_out(o_ptr), .ub_rd_addr_out(o_addr),
        .ub_rd_row_size_out(o_row), .ub_rd_col_size_out(o_col), .vpu_data_pathway_out(o_pw),
        .sys_switch_out(sw), .sync_pulse_out(sync), .busy_out(busy), .fifo_count_out(count),
        .cmd_done_count_out(done), .err_timeout_out(err)
    );

    tpu_cmd_sequencer #(.SYSTOLIC_ARRAY_WIDTH(N4), .CMD_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u_dut4 (
        .clk(clk), .rst(rst), .cmd_valid_in(cmd_valid4), .cmd_ready_out(ready4),
        .cmd_op_in(op), .cmd_transpose_in(tr), .cmd_ptr_select_in(ptr), .cmd_addr_in(addr),
        .cmd_row_size_in(row), .cmd_col_size_in(col), .cmd_vpu_pathway_in(pw),
        .vpu_valid_in(vpu4), .err_clear_in(err_clear4), .ub_rd_start_out(start4),
        .ub_rd_transpose_out(o_tr4), .ub_ptr_select_out(o_ptr4), .ub_rd_addr_out(o_addr4),
        .ub_rd_row_size_out(o_row4), .ub_rd_col_size_out(o_col4), .vpu_data_pathway_out(o_pw4),
        .sys_switch_out(sw4), .sync_pulse_out(sync4), .busy_out(busy4), .fifo_count_out(count4),
        .cmd_done_count_out(done4), .err_timeout_out(err4)
    );

    int checks = 0;
    int failures = 0;
    int exp_done = 0;

    typedef logic [64:0] rec_t;
    rec_t sb_q[$];
    logic        m_tr;
    logic [8:0]  m_ptr;
    logic [15:0] m_addr, m_row, m_col;
    logic [3:0]  m_pw;

    typedef struct {
        logic [1:0]  op;
        logic        tr;
        logic [8:0]  ptr;
        logic [15:0] addr, row, col;
        logic [3:0]  pw;
        int          beats;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected issue-cycle pulses plus the held fields visible during that cycle
    task automatic sb_push(input logic [1:0] o, input logic t, input logic [8:0] p,
                           input logic [15:0] a, input logic [15:0] r, input logic [15:0] c,
                           input logic [3:0] w);
        logic lc, st, s, y;
        lc = (o == OP_LOAD) || (o == OP_COMPUTE);
        if (lc) begin
            m_tr = t; m_ptr = p; m_addr = a; m_row = r; m_col = c; m_pw = w;
        end
        st = lc && (r != 16'd0);
        s  = ((o == OP_COMPUTE) && (r != 16'd0)) || (o == OP_SWITCH);
        y  = (o == OP_SYNC);
        if (st || s || y) sb_q.push_back({st, s, y, m_tr, m_ptr, m_addr, m_row, m_col, m_pw});
    endtask

    task automatic set_cmd(input logic [1:0] o, input logic t, input logic [8:0] p,
                           input logic [15:0] a, input logic [15:0] r, input logic [15:0] c,
                           input logic [3:0] w);
        op = o; tr = t; ptr = p; addr = a; row = r; col = c; pw = w;
    endtask

    task automatic push_cmd(input logic [1:0] o, input logic t, input logic [8:0] p,
                            input logic [15:0] a, input logic [15:0] r, input logic [15:0] c,
                            input logic [3:0] w);
        set_cmd(o, t, p, a, r, c, w);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        sb_push(o, t, p, a, r, c, w);
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (!rst && (start || sw || sync)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {start, sw, sync}, 3'b000);
            end else begin
                e = sb_q.pop_front();
                check("issue_cycle", {start, sw, sync, o_tr, o_ptr, o_addr, o_row, o_col, o_pw}, e);
            end
        end
    end

    initial begin
        int lat;
        rst = 1'b1; cmd_valid = 1'b0; cmd_valid4 = 1'b0; err_clear = 1'b0; err_clear4 = 1'b0;
        vpu = '0; vpu4 = '0;
        set_cmd(OP_LOAD, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        m_tr = 0; m_ptr = 0; m_addr = 0; m_row = 0; m_col = 0; m_pw = 0;

        vecs[0] = '{OP_COMPUTE, 1'b0, 9'h004, 16'h0010, 16'd3, 16'd2, 4'b1111, 3, 4};
        vecs[1] = '{OP_LOAD,    1'b1, 9'h1FF, 16'h1234, 16'd5, 16'd7, 4'h3,    0, 8};
        vecs[2] = '{OP_COMPUTE, 1'b1, 9'h055, 16'hBEEF, 16'd1, 16'd9, 4'h5,    1, 2};
        vecs[3] = '{OP_SWITCH,  1'b0, 9'h0AA, 16'h7777, 16'd8, 16'd8, 4'h8,    0, 2};
        vecs[4] = '{OP_SYNC,    1'b1, 9'h111, 16'h5555, 16'd4, 16'd4, 4'h9,    0, 2};
        vecs[5] = '{OP_LOAD,    1'b0, 9'h033, 16'h0040, 16'd0, 16'd3, 4'h6,    0, 2};
        vecs[6] = '{OP_COMPUTE, 1'b1, 9'h077, 16'h0080, 16'd0, 16'd5, 4'hC,    0, 2};
        vecs[7] = '{OP_LOAD,    1'b1, 9'h100, 16'hFFFF, 16'd1, 16'd1, 4'h1,    0, 4};

        repeat (2) tick();
        check("reset_outputs", {start, o_tr, o_ptr, o_addr, o_row, o_col, o_pw, sw, sync, busy, count, done, err}, '0);
        check("reset_ready", ready, 1'b1);
        check("reset_n4", {ready4, count4, done4, busy4}, {1'b1, 3'd0, 16'd0, 1'b0});
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            push_cmd(vecs[i].op, vecs[i].tr, vecs[i].ptr, vecs[i].addr, vecs[i].row, vecs[i].col, vecs[i].pw);
            lat = -1;
            for (int c = 1; c <= 64 && lat < 0; c++) begin
                vpu = (c >= 2 && c <= vecs[i].beats + 1) ? 2'b10 : 2'b00;
                tick();
                if (done != 16'(exp_done)) lat = c;
            end
            vpu = '0;
            exp_done++;
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_done", i), done, exp_done);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // LOAD on the four-lane instance: row 5 plus three lanes of skew
        set_cmd(OP_LOAD, 1'b0, 9'h0AA, 16'h0200, 16'd5, 16'd4, 4'h2);
        cmd_valid4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 64 && lat < 0; c++) begin
            tick();
            if (done4 != 16'd0) lat = c;
        end
        check("n4_load_latency", lat, 10);
        check("n4_load_done", {done4, o_row4}, {16'd1, 16'd5});

        // FIFO fill while a COMPUTE waits for writeback
        push_cmd(OP_COMPUTE, 1'b0, 9'h002, 16'h0100, 16'd2, 16'd2, 4'h4);
        set_cmd(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        cmd_valid = 1'b1;
        tick(); sb_push(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        check("fifo_pop_push_count", count, 3'd1);
        set_cmd(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        tick(); sb_push(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        set_cmd(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        tick(); sb_push(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        set_cmd(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        tick(); sb_push(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        check("fifo_full", {ready, count, busy}, {1'b0, 3'd4, 1'b1});
        set_cmd(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        repeat (2) tick();
        check("fifo_full_reject", count, 3'd4);
        vpu = 2'b10;
        repeat (2) tick();
        vpu = '0;
        exp_done++;
        check("fifo_head_retire", {done, count}, {16'(exp_done), 3'd4});
        tick();
        check("fifo_pop_when_full", {ready, count}, {1'b1, 3'd3});
        tick();
        cmd_valid = 1'b0;
        sb_push(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        check("fifo_refill", count, 3'd4);
        exp_done += 5;
        for (int c = 0; c < 40 && done != 16'(exp_done); c++) tick();
        check("fifo_drain", {done, busy, count}, {16'(exp_done), 1'b0, 3'd0});

        // Writeback timeout: one beat out of two, queued SYNC still runs
        push_cmd(OP_COMPUTE, 1'b1, 9'h00F, 16'h0300, 16'd2, 16'd1, 4'hA);
        set_cmd(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        sb_push(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        tick();
        vpu = 2'b10;
        tick();
        vpu = '0;
        repeat (15) tick();
        check("timeout_not_early", err, 1'b0);
        tick();
        check("timeout_set", {err, done, busy}, {1'b1, 16'(exp_done), 1'b1});
        repeat (2) tick();
        exp_done++;
        check("timeout_next_cmd", {err, done}, {1'b1, 16'(exp_done)});
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("timeout_clear", err, 1'b0);

        // Reset during WAIT_WB with two commands queued
        push_cmd(OP_COMPUTE, 1'b0, 9'h0F0, 16'h0400, 16'd3, 16'd3, 4'h7);
        push_cmd(OP_SWITCH, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        push_cmd(OP_SYNC, 1'b0, 9'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        tick();
        check("prereset_queue", {count, busy}, {3'd2, 1'b1});
        rst = 1'b1;
        sb_q.delete();
        m_tr = 0; m_ptr = 0; m_addr = 0; m_row = 0; m_col = 0; m_pw = 0;
        tick();
        check("midreset_outputs", {start, o_tr, o_ptr, o_addr, o_row, o_col, o_pw, sw, sync, busy, count, done, err}, '0);
        check("midreset_ready", ready, 1'b1);
        rst = 1'b0;
        exp_done = 0;
        repeat (6) tick();
        check("postreset_quiet", {done, busy, count}, {16'd0, 1'b0, 3'd0});

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
